ram1_responder: RTL and testbench

RAM1_RESPONDER -- requirements
Module: ram1_responder

---
 rtl/ram1_pkg.sv | 7 +
 rtl/ram1_storage.sv | 19 +
 rtl/ram1_responder.sv | 129 ++++++++++++
 tb/tb_ram1_responder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram1_pkg.sv
// ram1_pkg: shared state encoding and default geometry for the ram1 bus responder.
package ram1_pkg;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_READ_LAT = 2;
    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DRIVE, WR_ACTIVE} state_t;
endpackage

// File: rtl/ram1_storage.sv
// ram1_storage: word array with one synchronous write port and one registered read port.
module ram1_storage #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/ram1_responder.sv
// ram1_responder: asynchronous-SRAM-style bus responder with fixed read latency,
// bus-commit writes, protocol-clash detection and a backdoor preload port.
module ram1_responder
    import ram1_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int READ_LAT = DEF_READ_LAT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ram1EN,
    input  logic              ram1OE,
    input  logic              ram1WE,
    input  logic [15:0]       ram1Addr,
    inout  wire  [DATA_W-1:0] ram1Data,
    input  logic              loadEn,
    input  logic [ADDR_W-1:0] loadAddr,
    input  logic [DATA_W-1:0] loadData,
    output logic              loadAck,
    output logic              protoErr,
    output logic              busy,
    output logic [15:0]       writeCount
);
    localparam int CW = 3;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d, bus_addr;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata;
    logic              proto_q, proto_d, ack_q, commit, load_ok;
    logic [15:0]       wcnt_q;
    logic              rd_req, wr_req, clash;
    logic              unused_addr_hi;

    assign bus_addr       = ram1Addr[ADDR_W-1:0];
    assign unused_addr_hi = ^ram1Addr[15:ADDR_W];
    assign rd_req = !ram1EN && !ram1OE && ram1WE;
    assign wr_req = !ram1EN && ram1OE && !ram1WE;
    assign clash  = !ram1EN && !ram1OE && !ram1WE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        proto_d = proto_q;
        commit  = 1'b0;
        load_ok = 1'b0;
        if (clash) begin
            proto_d = 1'b1;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rd_req) begin
                        state_d = RD_WAIT;
                        addr_d  = bus_addr;
                        cnt_d   = CW'(READ_LAT - 1);
                    end else if (wr_req) begin
                        state_d = WR_ACTIVE;
                        addr_d  = bus_addr;
                        wdata_d = ram1Data;
                    end else begin
                        load_ok = loadEn;
                    end
                end
                RD_WAIT, RD_DRIVE: begin
                    if (!rd_req) begin
                        state_d = IDLE;
                    end else if (bus_addr != addr_q) begin
                        state_d = RD_WAIT;
                        addr_d  = bus_addr;
                        cnt_d   = CW'(READ_LAT - 1);
                    end else if (state_q == RD_WAIT) begin
                        if (cnt_q == '0) state_d = RD_DRIVE;
                        else cnt_d = cnt_q - 1'b1;
                    end
                end
                WR_ACTIVE: begin
                    if (wr_req) begin
                        addr_d  = bus_addr;
                        wdata_d = ram1Data;
                    end else begin
                        commit  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            proto_q <= 1'b0;
            ack_q   <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            proto_q <= proto_d;
            ack_q   <= load_ok;
            wcnt_q  <= wcnt_q + 16'(commit);
        end
    end

    // Bus commit and backdoor load never coincide: loads are only taken in IDLE.
    ram1_storage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_storage (
        .clk_i   (CLK),
        .we_i    (!RST && (commit || load_ok)),
        .waddr_i (commit ? addr_q : loadAddr),
        .wdata_i (commit ? wdata_q : loadData),
        .raddr_i (addr_q),
        .rdata_o (rdata)
    );

    assign ram1Data   = (state_q == RD_DRIVE) ? rdata : {DATA_W{1'bz}};
    assign loadAck    = ack_q;
    assign protoErr   = proto_q;
    assign busy       = state_q != IDLE;
    assign writeCount = wcnt_q;
endmodule

// File: tb/tb_ram1_responder.sv
// tb_ram1_responder: directed checks of read latency, writes, address switch, clash, reset and backdoor loads.
module tb_ram1_responder;
    logic        CLK = 1'b0;
    logic        RST, ram1EN, ram1OE, ram1WE, loadEn;
    logic [15:0] ram1Addr, loadData, tb_dq;
    logic [7:0]  loadAddr;
    logic        tb_drv, loadAck, protoErr, busy;
    logic [15:0] writeCount;
    wire  [15:0] ram1Data;
    int          checks = 0, errors = 0;

    assign ram1Data = tb_drv ? tb_dq : 16'hzzzz;

    ram1_responder dut (
        .CLK(CLK), .RST(RST), .ram1EN(ram1EN), .ram1OE(ram1OE), .ram1WE(ram1WE),
        .ram1Addr(ram1Addr), .ram1Data(ram1Data), .loadEn(loadEn), .loadAddr(loadAddr),
        .loadData(loadData), .loadAck(loadAck), .protoErr(protoErr), .busy(busy),
        .writeCount(writeCount)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Undriven bus resolves to Z in 4-state simulators and to 0 in 2-state ones.
    task automatic chk_rel(input string tag);
        checks++;
        assert (ram1Data === 16'hzzzz || ram1Data === 16'h0000) else begin
            errors++;
            $error("FAIL %s observed %h expected released", tag, ram1Data);
        end
    endtask

    task automatic bus_idle();
        ram1EN = 1'b1; ram1OE = 1'b1; ram1WE = 1'b1; tb_drv = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a);
        ram1EN = 1'b0; ram1OE = 1'b0; ram1WE = 1'b1; ram1Addr = a; tb_drv = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        ram1EN = 1'b0; ram1OE = 1'b1; ram1WE = 1'b0; ram1Addr = a; tb_drv = 1'b1; tb_dq = d;
    endtask

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        loadEn = 1'b1; loadAddr = a; loadData = d;
        step();
        chk("load_ack", {15'b0, loadAck}, 16'h1);
        loadEn = 1'b0;
        step();
        chk("load_ack_pulse", {15'b0, loadAck}, 16'h0);
    endtask

    task automatic read_expect(input string tag, input logic [15:0] a, input logic [15:0] exp);
        rd(a);
        step();
        chk_rel({tag, "_lat0"});
        step();
        chk_rel({tag, "_lat1"});
        step();
        chk({tag, "_data"}, ram1Data, exp);
        bus_idle();
        step();
        chk_rel({tag, "_end"});
    endtask

    initial begin
        RST = 1'b1; loadEn = 1'b0; loadAddr = '0; loadData = '0; ram1Addr = '0; tb_dq = '0;
        bus_idle();
        step(); step();
        RST = 1'b0;
        chk("rst_busy", {15'b0, busy}, 16'h0);
        chk("rst_proto", {15'b0, protoErr}, 16'h0);
        chk("rst_ack", {15'b0, loadAck}, 16'h0);
        chk("rst_wcnt", writeCount, 16'h0);
        chk_rel("rst_bus");

        preload(8'h05, 16'h0012);
        preload(8'h01, 16'h1111);
        preload(8'h02, 16'h2222);
        preload(8'h20, 16'h3333);

        // Read latency 2: released for the first two edges, data from edge 2 until OE rises
        rd(16'h0005);
        step();
        chk("rd05_busy", {15'b0, busy}, 16'h1);
        chk_rel("rd05_e0");
        step();
        chk_rel("rd05_e1");
        step();
        chk("rd05_e2", ram1Data, 16'h0012);
        step();
        chk("rd05_hold", ram1Data, 16'h0012);
        ram1OE = 1'b1;
        step();
        chk_rel("rd05_oe_off");
        chk("rd05_idle", {15'b0, busy}, 16'h0);
        bus_idle();

        // Write with data changing, last value wins
        wr(16'h0010, 16'h1234);
        step();
        chk("wr_busy", {15'b0, busy}, 16'h1);
        tb_dq = 16'h5678;
        step();
        tb_dq = 16'hBEEF;
        step();
        chk("wr_nocommit_yet", writeCount, 16'h0);
        bus_idle();
        step();
        chk("wr_count1", writeCount, 16'h1);
        chk("wr_idle", {15'b0, busy}, 16'h0);
        read_expect("rd10", 16'h0010, 16'hBEEF);

        // Upper address bits are ignored
        read_expect("rd_hi", 16'hAB05, 16'h0012);

        // Address switch during RD_DRIVE restarts latency
        rd(16'h0001);
        step(); step(); step();
        chk("sw_first", ram1Data, 16'h1111);
        ram1Addr = 16'h0002;
        step();
        chk_rel("sw_rel0");
        chk("sw_busy", {15'b0, busy}, 16'h1);
        step();
        chk_rel("sw_rel1");
        step();
        chk("sw_second", ram1Data, 16'h2222);
        bus_idle();
        step();

        // OE and WE both low during a write
        wr(16'h0020, 16'h9999);
        step();
        ram1OE = 1'b0;
        step();
        chk("clash_proto", {15'b0, protoErr}, 16'h1);
        chk("clash_idle", {15'b0, busy}, 16'h0);
        bus_idle();
        step();
        chk("clash_sticky", {15'b0, protoErr}, 16'h1);
        chk("clash_wcnt", writeCount, 16'h1);
        read_expect("rd20", 16'h0020, 16'h3333);

        // Reset during RD_DRIVE
        rd(16'h0005);
        step(); step(); step();
        chk("rstrd_data", ram1Data, 16'h0012);
        RST = 1'b1;
        step();
        chk_rel("rstrd_rel");
        chk("rstrd_busy", {15'b0, busy}, 16'h0);
        chk("rstrd_proto", {15'b0, protoErr}, 16'h0);
        RST = 1'b0;
        bus_idle();
        step();

        // Reset during WR_ACTIVE
        wr(16'h0005, 16'h7777);
        step();
        RST = 1'b1;
        step();
        chk("rstwr_busy", {15'b0, busy}, 16'h0);
        chk("rstwr_wcnt", writeCount, 16'h0);
        RST = 1'b0;
        bus_idle();
        step();
        chk("rstwr_still", writeCount, 16'h0);
        read_expect("rd05_after", 16'h0005, 16'h0012);

        // Backdoor load outside IDLE is dropped
        rd(16'h0010);
        step();
        loadEn = 1'b1; loadAddr = 8'h10; loadData = 16'h4444;
        step();
        chk("ld_rdwait_ack", {15'b0, loadAck}, 16'h0);
        loadEn = 1'b0;
        step();
        chk("ld_rdwait_word", ram1Data, 16'hBEEF);
        bus_idle();
        step();

        // Backdoor load alongside a bus request in IDLE is dropped
        loadEn = 1'b1; loadAddr = 8'h01; loadData = 16'h5555;
        rd(16'h0001);
        step();
        chk("ld_req_ack", {15'b0, loadAck}, 16'h0);
        loadEn = 1'b0;
        step(); step();
        chk("ld_req_word", ram1Data, 16'h1111);
        bus_idle();
        step();

        // Rewriting the same word still counts
        wr(16'h0010, 16'hBEEF);
        step();
        bus_idle();
        step();
        chk("same_wcnt", writeCount, 16'h1);
        read_expect("rd10_same", 16'h0010, 16'hBEEF);

        // Commit via EN rising
        wr(16'h0002, 16'hCAFE);
        step();
        ram1EN = 1'b1;
        step();
        chk("en_commit_wcnt", writeCount, 16'h2);
        bus_idle();
        read_expect("rd02_new", 16'h0002, 16'hCAFE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
